// File: rtl/sdrc_wb_arbiter.sv
// Two-master round-robin Wishbone arbiter in front of the SDRAM controller slave port.
// Grant is held for the whole cycle; a stalled strobe times out with a one-cycle err.
module sdrc_wb_arbiter #(
  parameter int unsigned APP_AW = 26,
  parameter int unsigned dw     = 32,
  parameter int unsigned TO_CYC = 255
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,

  input  logic              m0_cyc_i,
  input  logic              m0_stb_i,
  input  logic              m0_we_i,
  input  logic [APP_AW-1:0] m0_addr_i,
  input  logic [dw-1:0]     m0_dat_i,
  input  logic [dw/8-1:0]   m0_sel_i,
  input  logic [2:0]        m0_cti_i,
  output logic              m0_ack_o,
  output logic              m0_err_o,
  output logic [dw-1:0]     m0_dat_o,

  input  logic              m1_cyc_i,
  input  logic              m1_stb_i,
  input  logic              m1_we_i,
  input  logic [APP_AW-1:0] m1_addr_i,
  input  logic [dw-1:0]     m1_dat_i,
  input  logic [dw/8-1:0]   m1_sel_i,
  input  logic [2:0]        m1_cti_i,
  output logic              m1_ack_o,
  output logic              m1_err_o,
  output logic [dw-1:0]     m1_dat_o,

  output logic              s_cyc_o,
  output logic              s_stb_o,
  output logic              s_we_o,
  output logic [APP_AW-1:0] s_addr_o,
  output logic [dw-1:0]     s_dat_o,
  output logic [dw/8-1:0]   s_sel_o,
  output logic [2:0]        s_cti_o,
  input  logic              s_ack_i,
  input  logic [dw-1:0]     s_dat_i,

  output logic [1:0]        gnt_o
);

  localparam int unsigned CNT_W  = 8;
  localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TO_CYC);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic             last, last_nxt;     // 1: m1 was granted most recently
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [1:0]       lock, lock_nxt;     // per-master lockout after a timeout
  logic             own0, own1;
  logic             req0, req1;

  // State register
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state <= IDLE;
      last  <= 1'b1;
      cnt   <= '0;
      lock  <= '0;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
      cnt   <= cnt_nxt;
      lock  <= lock_nxt;
    end
  end

  // Next state, timeout counter, and the combinational slave/master routing
  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    cnt_nxt   = '0;
    lock_nxt  = lock;
    m0_err_o  = 1'b0;
    m1_err_o  = 1'b0;
    s_cyc_o   = 1'b0;
    s_stb_o   = 1'b0;
    s_we_o    = 1'b0;
    s_addr_o  = '0;
    s_dat_o   = '0;
    s_sel_o   = '0;
    s_cti_o   = '0;

    // A locked-out master is released once its cyc has been seen low
    if (!m0_cyc_i) lock_nxt[0] = 1'b0;
    if (!m1_cyc_i) lock_nxt[1] = 1'b0;

    req0 = m0_cyc_i && !lock[0];
    req1 = m1_cyc_i && !lock[1];
    own0 = (state == GNT0) && !wb_rst_i;
    own1 = (state == GNT1) && !wb_rst_i;

    case (state)
      IDLE: begin
        if (req0 && (!req1 || last)) begin
          state_nxt = GNT0;
          last_nxt  = 1'b0;
        end else if (req1) begin
          state_nxt = GNT1;
          last_nxt  = 1'b1;
        end
      end
      GNT0: begin
        if (!m0_cyc_i) begin
          state_nxt = IDLE;
        end else if (s_ack_i || !m0_stb_i) begin
          cnt_nxt = '0;
        end else if (cnt == TO_VAL) begin
          m0_err_o    = !wb_rst_i;
          state_nxt   = IDLE;
          lock_nxt[0] = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      GNT1: begin
        if (!m1_cyc_i) begin
          state_nxt = IDLE;
        end else if (s_ack_i || !m1_stb_i) begin
          cnt_nxt = '0;
        end else if (cnt == TO_VAL) begin
          m1_err_o    = !wb_rst_i;
          state_nxt   = IDLE;
          lock_nxt[1] = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (own0) begin
      s_cyc_o  = m0_cyc_i;
      s_stb_o  = m0_stb_i;
      s_we_o   = m0_we_i;
      s_addr_o = m0_addr_i;
      s_dat_o  = m0_dat_i;
      s_sel_o  = m0_sel_i;
      s_cti_o  = m0_cti_i;
    end else if (own1) begin
      s_cyc_o  = m1_cyc_i;
      s_stb_o  = m1_stb_i;
      s_we_o   = m1_we_i;
      s_addr_o = m1_addr_i;
      s_dat_o  = m1_dat_i;
      s_sel_o  = m1_sel_i;
      s_cti_o  = m1_cti_i;
    end
  end

  assign m0_ack_o = s_ack_i && own0;
  assign m1_ack_o = s_ack_i && own1;
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign gnt_o    = {own1, own0};

endmodule
